// File: rtl/contador_checker_rfwild_pkg.sv
// rtl/contador_checker_rfwild_pkg.sv - shared types and defaults for the counter-bus sequence checker
package contador_checker_rfwild_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED
  } state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_IN_STAGES  = 2;
  localparam int DEF_ERR_W      = 8;

  // Also used by the counter-chip bench, keep in step with it.
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_LOSS_COUNT = 3;

endpackage

// File: rtl/rfwild_in_pipe.sv
// rtl/rfwild_in_pipe.sv - WIDTH x STAGES register chain behind input pads
module rfwild_in_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/contador_checker_rfwild.sv
// rtl/contador_checker_rfwild.sv - locks onto the count-by-one pad bus and flags out-of-sequence words
module contador_checker_rfwild
  import contador_checker_rfwild_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int IN_STAGES  = DEF_IN_STAGES,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int LOSS_COUNT = DEF_LOSS_COUNT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] contador_in,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_COUNT);

  state_t           state;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic             s_valid;
  logic             primed;
  logic [3:0]       match_cnt;
  logic [3:0]       miss_cnt;

  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] s_inc;
  logic [WIDTH-1:0] expected_inc;
  logic [3:0]       match_inc;
  logic [3:0]       miss_inc;
  logic             miss;
  logic             err_bump;

  rfwild_in_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (IN_STAGES)
  ) u_data_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (contador_in),
    .q     (s)
  );

  // Enable travels with the data so only words sampled while enabled are judged.
  rfwild_in_pipe #(
    .WIDTH  (1),
    .STAGES (IN_STAGES)
  ) u_valid_pipe (
    .clk   (clk),
    .reset (reset),
    .d     (enable),
    .q     (s_valid)
  );

  always_comb begin
    prev_inc     = prev + WIDTH'(1);
    s_inc        = s + WIDTH'(1);
    expected_inc = expected + WIDTH'(1);
    match_inc    = match_cnt + 4'd1;
    miss_inc     = miss_cnt + 4'd1;
    miss         = (state == ST_LOCKED) && (s != expected);
    err_bump     = enable && miss && !(&err_count);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      prev      <= '0;
      primed    <= 1'b0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      expected  <= '0;
      locked    <= 1'b0;
      error     <= 1'b0;
    end else begin
      error <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        prev      <= '0;
        primed    <= 1'b0;
        match_cnt <= '0;
        miss_cnt  <= '0;
        expected  <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            if (s_valid) begin
              prev     <= s;
              expected <= s_inc;
              if (!primed) begin
                primed <= 1'b1;
              end else if (s == prev_inc) begin
                if (match_inc == LOCK_TGT) begin
                  state     <= ST_LOCKED;
                  locked    <= 1'b1;
                  match_cnt <= '0;
                  miss_cnt  <= '0;
                end else begin
                  match_cnt <= match_inc;
                end
              end else begin
                match_cnt <= '0;
              end
            end
          end
          ST_LOCKED: begin
            // Prediction free-runs; a miss never re-centres it.
            expected <= expected_inc;
            prev     <= s;
            if (miss) begin
              error <= 1'b1;
              if (miss_inc == LOSS_TGT) begin
                state     <= ST_ACQUIRE;
                locked    <= 1'b0;
                primed    <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (err_bump) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_contador_checker_rfwild.sv
// tb/tb_contador_checker_rfwild.sv - randomized self-checking bench for contador_checker_rfwild
module tb_contador_checker_rfwild;

  localparam int IN_ST = 2;
  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] contador_in = 4'd0;
  logic       locked;
  logic       error;
  logic [7:0] err_count;
  logic [3:0] expected;

  int checks = 0;
  int errors = 0;
  int seq = 0;

  // reference model: words judged IN_ST edges after they are sampled
  int   m_phase, m_ref, m_good, m_bad, m_pred, m_total;
  bit   m_have_ref, m_lock, m_pulse;
  logic [3:0] q_w[$];
  logic       q_en[$];

  always #5 clk = ~clk;

  contador_checker_rfwild #(
    .WIDTH(4), .IN_STAGES(IN_ST), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .ERR_W(8)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
    .contador_in(contador_in), .locked(locked), .error(error),
    .err_count(err_count), .expected(expected)
  );

  function automatic void model_reset();
    m_phase = 0; m_ref = 0; m_good = 0; m_bad = 0; m_pred = 0; m_total = 0;
    m_have_ref = 0; m_lock = 0; m_pulse = 0;
    q_w.delete(); q_en.delete();
  endfunction

  function automatic void model_edge(input logic [3:0] w, input logic en, input logic clr);
    int s; bit sv; bit missed;
    q_w.push_back(w); q_en.push_back(en);
    s = 0; sv = 0; missed = 0;
    if (q_w.size() > IN_ST) begin
      s = int'(q_w[0]); sv = q_en[0];
      void'(q_w.pop_front()); void'(q_en.pop_front());
    end
    if (!en) begin
      m_phase = 0; m_lock = 0; m_have_ref = 0; m_good = 0; m_bad = 0; m_pred = 0; m_ref = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (sv) begin
        if (!m_have_ref) m_have_ref = 1;
        else if (s == (m_ref + 1) % 16) begin
          m_good++;
          if (m_good == LOCK_N) begin m_phase = 2; m_lock = 1; m_good = 0; m_bad = 0; end
        end else m_good = 0;
        m_ref = s;
        m_pred = (s + 1) % 16;
      end
    end else begin
      if (s != m_pred) begin
        missed = 1;
        m_bad++;
        if (m_bad == LOSS_N) begin m_phase = 1; m_lock = 0; m_good = 0; m_bad = 0; m_have_ref = 0; end
      end else m_bad = 0;
      m_pred = (m_pred + 1) % 16;
      m_ref = s;
    end
    m_pulse = missed;
    if (clr) m_total = 0;
    else if (missed && m_total < 255) m_total++;
  endfunction

  function automatic logic [13:0] mvec();
    logic [7:0] t; logic [3:0] p;
    t = 8'(m_total); p = 4'(m_pred);
    return {m_lock, m_pulse, t, p};
  endfunction

  task automatic step(input logic [3:0] w, input logic en, input logic clr);
    contador_in = w; enable = en; clr_err = clr;
    @(posedge clk);
    model_edge(w, en, clr);
    #1;
  endtask

  task automatic assert_reset();
    #2; reset = 1'b1; model_reset(); #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_reset();
    enable = 1'b1; contador_in = 4'd0;
    #1; reset = 1'b1; model_reset(); #1;
    checks++;
    if ({locked, error, err_count, expected} !== 14'd0) begin
      errors++; $display("FAIL reset_state got %h want 0", {locked, error, err_count, expected});
    end
    release_reset();
    seq = 0;
  endtask

  task automatic test_clean_lock();
    int pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      step(4'(seq), 1'b1, 1'b0); seq++;
      pulses += int'(error);
      checks++;
      if ({locked, error, err_count, expected} !== mvec()) begin
        errors++; $display("FAIL clean_model step %0d got %h want %h", k, {locked, error, err_count, expected}, mvec());
      end
      if (k == 6) begin
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL clean_early_lock got %b want 0", locked); end
      end
      if (k == 7) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL clean_lock_at_7 got %b want 1", locked); end
      end
    end
    checks++;
    if (pulses != 0 || err_count !== 8'd0) begin
      errors++; $display("FAIL clean_wrap_errors got pulses %0d count %0d want 0 0", pulses, err_count);
    end
  endtask

  task automatic test_single_miss();
    int delay = $urandom_range(0, 20);
    for (int i = 0; i < delay; i++) begin step(4'(seq), 1'b1, 1'b0); seq++; end
    for (int i = 0; i < 16; i++) begin
      if (seq % 16 == 5) break;
      step(4'(seq), 1'b1, 1'b0); seq++;
    end
    step(4'd9, 1'b1, 1'b0); seq++;
    for (int j = 1; j <= 6; j++) begin
      step(4'(seq), 1'b1, 1'b0); seq++;
      checks++;
      if ({locked, error, err_count, expected} !== mvec()) begin
        errors++; $display("FAIL miss_model off %0d got %h want %h", j, {locked, error, err_count, expected}, mvec());
      end
      checks++;
      if (error !== (j == 2) || locked !== 1'b1) begin
        errors++; $display("FAIL miss_pulse off %0d got err %b lock %b want err %b lock 1", j, error, locked, j == 2);
      end
    end
    checks++;
    if (err_count !== 8'd1) begin errors++; $display("FAIL miss_count got %0d want 1", err_count); end
  endtask

  task automatic test_stuck_loss();
    int target = $urandom_range(8, 12);
    int r;
    for (int i = 0; i < 16; i++) begin
      if (seq % 16 == target) break;
      step(4'(seq), 1'b1, 1'b0); seq++;
    end
    for (int j = 0; j < 8; j++) begin
      step(4'd7, 1'b1, 1'b0); seq++;
      checks++;
      if (error !== (j >= 2 && j <= 4)) begin
        errors++; $display("FAIL stuck_pulse off %0d got %b want %b", j, error, (j >= 2 && j <= 4));
      end
      checks++;
      if (locked !== (j < 4)) begin
        errors++; $display("FAIL stuck_locked off %0d got %b want %b", j, locked, (j < 4));
      end
    end
    r = $urandom_range(0, 15);
    if (r == 8) r = 9;
    for (int j = 0; j < 10; j++) begin
      step(4'((r + j) % 16), 1'b1, 1'b0);
      checks++;
      if ({locked, error, err_count, expected} !== mvec()) begin
        errors++; $display("FAIL relock_model off %0d got %h want %h", j, {locked, error, err_count, expected}, mvec());
      end
      checks++;
      if (locked !== (j >= 6)) begin
        errors++; $display("FAIL relock_time off %0d got %b want %b", j, locked, (j >= 6));
      end
      if (j == 6) begin
        checks++;
        if (expected !== 4'((r + 5) % 16)) begin
          errors++; $display("FAIL relock_expected got %0d want %0d", expected, (r + 5) % 16);
        end
      end
    end
    seq = r + 10;
    checks++;
    if (err_count !== 8'd4) begin errors++; $display("FAIL stuck_count got %0d want 4", err_count); end
  endtask

  task automatic test_saturation();
    int c, x;
    assert_reset(); release_reset();
    for (int p = 0; p < 92; p++) begin
      c = $urandom_range(0, 15); x = (c + 12) % 16;
      for (int j = 0; j < 8; j++) begin
        step((j < 5) ? 4'((c + j) % 16) : 4'(x), 1'b1, (p == 90 && j == 7));
        checks++;
        if ({locked, error, err_count, expected} !== mvec()) begin
          errors++; $display("FAIL sat_model p %0d j %0d got %h want %h", p, j, {locked, error, err_count, expected}, mvec());
        end
        if (p == 90 && j == 7) begin
          checks++;
          if (err_count !== 8'd0 || error !== 1'b1) begin
            errors++; $display("FAIL clr_with_miss got cnt %0d err %b want 0 1", err_count, error);
          end
        end
      end
      if (p == 89) begin
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", err_count); end
      end
    end
    checks++;
    if (err_count !== 8'd3) begin errors++; $display("FAIL post_clr_count got %0d want 3", err_count); end
  endtask

  task automatic test_reset_and_disable();
    assert_reset(); release_reset(); seq = $urandom_range(0, 15);
    for (int k = 0; k < 12; k++) begin step(4'(seq), 1'b1, 1'b0); seq++; end
    step(4'(seq + 3), 1'b1, 1'b0); seq++;
    for (int k = 0; k < 3; k++) begin step(4'(seq), 1'b1, 1'b0); seq++; end
    checks++;
    if (locked !== 1'b1 || err_count !== 8'd1) begin
      errors++; $display("FAIL pre_reset got lock %b cnt %0d want 1 1", locked, err_count);
    end
    assert_reset();
    checks++;
    if ({locked, error, err_count, expected} !== 14'd0) begin
      errors++; $display("FAIL midreset got %h want 0", {locked, error, err_count, expected});
    end
    release_reset();
    for (int k = 0; k < 10; k++) begin step(4'(seq), 1'b1, 1'b0); seq++; end
    step(4'(seq + 5), 1'b1, 1'b0); seq++;
    step(4'(seq), 1'b1, 1'b0); seq++;
    for (int k = 0; k < 6; k++) begin
      step(4'($urandom_range(0, 15)), 1'b0, 1'b0); seq++;
      checks++;
      if (locked !== 1'b0 || error !== 1'b0) begin
        errors++; $display("FAIL disable off %0d got lock %b err %b want 0 0", k, locked, error);
      end
    end
    for (int k = 0; k < 10; k++) begin
      step(4'(seq), 1'b1, 1'b0); seq++;
      checks++;
      if ({locked, error, err_count, expected} !== mvec()) begin
        errors++; $display("FAIL reenable_model step %0d got %h want %h", k, {locked, error, err_count, expected}, mvec());
      end
    end
  endtask

  task automatic test_random();
    int off_left = 0;
    logic [3:0] w;
    logic en, clr;
    for (int k = 0; k < 500; k++) begin
      if (off_left == 0 && $urandom_range(0, 59) == 0) off_left = $urandom_range(1, 3);
      en = (off_left == 0);
      if (off_left > 0) off_left--;
      w = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'(seq);
      clr = ($urandom_range(0, 39) == 0);
      step(w, en, clr); seq++;
      checks++;
      if ({locked, error, err_count, expected} !== mvec()) begin
        errors++; $display("FAIL random_model step %0d got %h want %h", k, {locked, error, err_count, expected}, mvec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_lock();
    test_single_miss();
    test_stuck_loss();
    test_saturation();
    test_reset_and_disable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
